// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared FSM states, digit maxima and field-width helper for the mm:ss BCD timer
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } timer_state_e;

    localparam int SEC_LOW_MAX   = 9;
    localparam int SEC_HIGH_MAX  = 5;
    localparam int MIN_DIGIT_MAX = 9;

    localparam int SEC_LOW_W   = 4;
    localparam int SEC_HIGH_W  = 3;
    localparam int MIN_DIGIT_W = 4;

    // Width of a packed {minutes MS..LS, sec_high, sec_low} field.
    function automatic int field_width(input int min_digits);
        return MIN_DIGIT_W * min_digits + SEC_HIGH_W + SEC_LOW_W;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - one modulo-N digit with carry/borrow chaining and a clamped load
module bcd_digit_counter #(
    parameter int MODULUS = 10,
    parameter int WIDTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_digit,
    input  logic             carry_in,
    input  logic             borrow_in,
    output logic             carry_out,
    output logic             borrow_out,
    output logic [WIDTH-1:0] digit
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    assign carry_out  = carry_in && (digit == MAX);
    assign borrow_out = borrow_in && (digit == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            digit <= '0;
        end else if (load) begin
            digit <= (load_digit > MAX) ? MAX : load_digit;
        end else if (carry_in) begin
            digit <= (digit == MAX) ? '0 : digit + 1'b1;
        end else if (borrow_in) begin
            digit <= (digit == '0) ? MAX : digit - 1'b1;
        end
    end

endmodule

// File: rtl/timer_mmss_bcd.sv
// rtl/timer_mmss_bcd.sv - mm:ss BCD up/down timer with run control; alarm output when TIMER_ALARM_EN is defined
module timer_mmss_bcd
    import timer_pkg::*;
#(
    parameter int MIN_DIGITS    = 2,
    parameter int STOP_AT_LIMIT = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enable,
    input  logic                                up_down,
    input  logic                                start,
    input  logic                                stop,
    input  logic                                load,
    input  logic [field_width(MIN_DIGITS)-1:0]  load_value,
    output logic [SEC_LOW_W-1:0]                sec_low_digit,
    output logic [SEC_HIGH_W-1:0]               sec_high_digit,
    output logic [MIN_DIGIT_W*MIN_DIGITS-1:0]   min_digits,
    output logic                                running,
    output logic                                done
`ifdef TIMER_ALARM_EN
    ,
    input  logic [field_width(MIN_DIGITS)-1:0]  alarm_value,
    output logic                                alarm
`endif
);

    localparam logic [SEC_LOW_W-1:0]   SL_MAX = SEC_LOW_W'(SEC_LOW_MAX);
    localparam logic [SEC_HIGH_W-1:0]  SH_MAX = SEC_HIGH_W'(SEC_HIGH_MAX);
    localparam logic [MIN_DIGIT_W-1:0] MD_MAX = MIN_DIGIT_W'(MIN_DIGIT_MAX);

    timer_state_e state;
    timer_state_e state_next;

    logic step_en;
    logic cnt_up;
    logic cnt_dn;
    logic fsm_done;
    logic wrap_done;
    logic sl_co;
    logic sl_bo;
    logic [MIN_DIGITS:0] m_co;
    logic [MIN_DIGITS:0] m_bo;
    logic min_all_max;
    logic min_all_zero;
    logic at_limit;
    logic near_limit;

    assign cnt_up = step_en && up_down;
    assign cnt_dn = step_en && !up_down;

    bcd_digit_counter #(.MODULUS(SEC_LOW_MAX + 1), .WIDTH(SEC_LOW_W)) u_sec_low (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_digit (load_value[SEC_LOW_W-1:0]),
        .carry_in   (cnt_up),
        .borrow_in  (cnt_dn),
        .carry_out  (sl_co),
        .borrow_out (sl_bo),
        .digit      (sec_low_digit)
    );

    bcd_digit_counter #(.MODULUS(SEC_HIGH_MAX + 1), .WIDTH(SEC_HIGH_W)) u_sec_high (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_digit (load_value[SEC_LOW_W +: SEC_HIGH_W]),
        .carry_in   (sl_co),
        .borrow_in  (sl_bo),
        .carry_out  (m_co[0]),
        .borrow_out (m_bo[0]),
        .digit      (sec_high_digit)
    );

    for (genvar i = 0; i < MIN_DIGITS; i++) begin : g_min
        bcd_digit_counter #(.MODULUS(MIN_DIGIT_MAX + 1), .WIDTH(MIN_DIGIT_W)) u_min (
            .clk        (clk),
            .reset      (reset),
            .load       (load),
            .load_digit (load_value[SEC_LOW_W + SEC_HIGH_W + MIN_DIGIT_W*i +: MIN_DIGIT_W]),
            .carry_in   (m_co[i]),
            .borrow_in  (m_bo[i]),
            .carry_out  (m_co[i+1]),
            .borrow_out (m_bo[i+1]),
            .digit      (min_digits[MIN_DIGIT_W*i +: MIN_DIGIT_W])
        );
    end

    // A carry or borrow leaving the top minute digit is a wrap through the limit.
    assign wrap_done = (STOP_AT_LIMIT == 0) && (m_co[MIN_DIGITS] || m_bo[MIN_DIGITS]);

    always_comb begin
        min_all_max  = 1'b1;
        min_all_zero = 1'b1;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (min_digits[MIN_DIGIT_W*i +: MIN_DIGIT_W] != MD_MAX) min_all_max = 1'b0;
            if (min_digits[MIN_DIGIT_W*i +: MIN_DIGIT_W] != '0)     min_all_zero = 1'b0;
        end
        if (up_down) begin
            at_limit   = min_all_max && (sec_high_digit == SH_MAX) && (sec_low_digit == SL_MAX);
            near_limit = min_all_max && (sec_high_digit == SH_MAX) && (sec_low_digit == SL_MAX - 1'b1);
        end else begin
            at_limit   = min_all_zero && (sec_high_digit == '0) && (sec_low_digit == '0);
            near_limit = min_all_zero && (sec_high_digit == '0) && (sec_low_digit == SEC_LOW_W'(1));
        end
    end

    always_comb begin
        state_next = state;
        step_en    = 1'b0;
        fsm_done   = 1'b0;
        if (load) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE, ST_HOLD: begin
                    if (start && !stop) state_next = ST_RUN;
                end
                ST_RUN: begin
                    // A stop strobe outranks the tick arriving in the same cycle.
                    if (stop) begin
                        state_next = ST_HOLD;
                    end else if (enable) begin
                        if (STOP_AT_LIMIT != 0 && at_limit) begin
                            fsm_done   = 1'b1;
                            state_next = ST_DONE;
                        end else begin
                            step_en = 1'b1;
                            if (STOP_AT_LIMIT != 0 && near_limit) begin
                                fsm_done   = 1'b1;
                                state_next = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_next = ST_DONE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= fsm_done || wrap_done;
        end
    end

    assign running = (state == ST_RUN);

`ifdef TIMER_ALARM_EN
    // Only a count that moved by a tick may raise the alarm, never a load.
    logic stepped_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stepped_q <= 1'b0;
        end else begin
            stepped_q <= step_en;
        end
    end

    assign alarm = stepped_q && ({min_digits, sec_high_digit, sec_low_digit} == alarm_value);
`endif

endmodule

// File: tb/tb_timer_mmss_bcd.sv
// tb/tb_timer_mmss_bcd.sv - vector table, corner sequences and randomized model check for timer_mmss_bcd
module tb_timer_mmss_bcd;

    localparam int MAXS     = 99 * 60 + 59;
    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_HOLD   = 2;
    localparam int S_DONE   = 3;
    localparam int ALARM_SS = 3;

    typedef struct {
        bit          rst;
        bit          ld;
        logic [14:0] lv;
        bit          ud;
        bit          st;
        bit          sp;
        bit          en;
    } in_t;

    typedef struct {
        in_t         i;
        logic [14:0] ecnt;
        bit          erun;
        bit          edone;
    } vec_t;

    typedef struct {
        int secs;
        int st;
        bit done;
        bit alarm;
    } mdl_t;

    logic clk = 1'b0;
    logic reset, enable, up_down, start, stop, load;
    logic [14:0] load_value;
    logic [3:0]  s_sl, w_sl;
    logic [2:0]  s_sh, w_sh;
    logic [7:0]  s_min, w_min;
    logic        s_run, w_run, s_done, w_done;
`ifdef TIMER_ALARM_EN
    logic [14:0] alarm_value;
    logic        s_alarm, w_alarm;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    mdl_t ms, mw;

    always #5 clk = ~clk;

    timer_mmss_bcd #(.MIN_DIGITS(2), .STOP_AT_LIMIT(1)) dut_stop (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .start(start),
        .stop(stop), .load(load), .load_value(load_value),
        .sec_low_digit(s_sl), .sec_high_digit(s_sh), .min_digits(s_min),
        .running(s_run), .done(s_done)
`ifdef TIMER_ALARM_EN
        , .alarm_value(alarm_value), .alarm(s_alarm)
`endif
    );

    timer_mmss_bcd #(.MIN_DIGITS(2), .STOP_AT_LIMIT(0)) dut_wrap (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .start(start),
        .stop(stop), .load(load), .load_value(load_value),
        .sec_low_digit(w_sl), .sec_high_digit(w_sh), .min_digits(w_min),
        .running(w_run), .done(w_done)
`ifdef TIMER_ALARM_EN
        , .alarm_value(alarm_value), .alarm(w_alarm)
`endif
    );

    function automatic logic [14:0] pack(input int mm, input int ss);
        logic [3:0] m1, m0, s0;
        logic [2:0] s1;
        m1 = 4'(mm / 10);
        m0 = 4'(mm % 10);
        s1 = 3'(ss / 10);
        s0 = 4'(ss % 10);
        return {m1, m0, s1, s0};
    endfunction

    function automatic logic [14:0] to_bcd(input int secs);
        return pack(secs / 60, secs % 60);
    endfunction

    function automatic int clampd(input int d, input int mx);
        return (d > mx) ? mx : d;
    endfunction

    function automatic int decode(input logic [14:0] lv);
        int m1, m0, s1, s0;
        m1 = clampd(int'(lv[14:11]), 9);
        m0 = clampd(int'(lv[10:7]), 9);
        s1 = clampd(int'(lv[6:4]), 5);
        s0 = clampd(int'(lv[3:0]), 9);
        return (m1 * 10 + m0) * 60 + s1 * 10 + s0;
    endfunction

    // Count held as plain seconds; limits are 0 and MAXS.
    function automatic mdl_t mnext(input mdl_t m, input bit halt, input in_t i);
        mdl_t n;
        int   lim;
        bit   stepped;
        n = m;
        n.done = 1'b0;
        stepped = 1'b0;
        lim = i.ud ? MAXS : 0;
        if (i.rst) begin
            n.secs = 0;
            n.st   = S_IDLE;
        end else if (i.ld) begin
            n.secs = decode(i.lv);
            n.st   = S_IDLE;
        end else if (m.st == S_IDLE || m.st == S_HOLD) begin
            if (i.st && !i.sp) n.st = S_RUN;
        end else if (m.st == S_RUN) begin
            if (i.sp) begin
                n.st = S_HOLD;
            end else if (i.en) begin
                if (halt && m.secs == lim) begin
                    n.done = 1'b1;
                    n.st   = S_DONE;
                end else if (!halt && m.secs == lim) begin
                    stepped = 1'b1;
                    n.secs  = i.ud ? 0 : MAXS;
                    n.done  = 1'b1;
                end else begin
                    stepped = 1'b1;
                    n.secs  = m.secs + (i.ud ? 1 : -1);
                    if (halt && n.secs == lim) begin
                        n.done = 1'b1;
                        n.st   = S_DONE;
                    end
                end
            end
        end
        n.alarm = stepped && (n.secs == ALARM_SS);
        return n;
    endfunction

    function automatic in_t mkin(input bit rst, input bit ld, input logic [14:0] lv,
                                 input bit ud, input bit st, input bit sp, input bit en);
        in_t r;
        r.rst = rst; r.ld = ld; r.lv = lv; r.ud = ud; r.st = st; r.sp = sp; r.en = en;
        return r;
    endfunction

    function automatic vec_t mkv(input in_t i, input int mm, input int ss, input bit run, input bit dn);
        vec_t v;
        v.i = i; v.ecnt = pack(mm, ss); v.erun = run; v.edone = dn;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input in_t i);
        reset = i.rst; load = i.ld; load_value = i.lv; up_down = i.ud;
        start = i.st; stop = i.sp; enable = i.en;
        @(posedge clk);
        ms = mnext(ms, 1'b1, i);
        mw = mnext(mw, 1'b0, i);
        @(negedge clk);
    endtask

    task automatic check_stop_model(input string tag);
        chk({tag, " stop count"},   {s_min, s_sh, s_sl}, to_bcd(ms.secs));
        chk({tag, " stop running"}, s_run,  (ms.st == S_RUN));
        chk({tag, " stop done"},    s_done, ms.done);
`ifdef TIMER_ALARM_EN
        chk({tag, " stop alarm"},   s_alarm, ms.alarm);
`endif
    endtask

    task automatic check_wrap_model(input string tag);
        chk({tag, " wrap count"},   {w_min, w_sh, w_sl}, to_bcd(mw.secs));
        chk({tag, " wrap running"}, w_run,  (mw.st == S_RUN));
        chk({tag, " wrap done"},    w_done, mw.done);
`ifdef TIMER_ALARM_EN
        chk({tag, " wrap alarm"},   w_alarm, mw.alarm);
`endif
    endtask

    initial begin
        vec_t tbl[$];
        logic [14:0] raw;
        bit ud;
        string nm;

        ms = '{secs: 0, st: S_IDLE, done: 1'b0, alarm: 1'b0};
        mw = ms;
        reset = 1'b1; load = 1'b0; load_value = '0; up_down = 1'b1;
        start = 1'b0; stop = 1'b0; enable = 1'b0;
`ifdef TIMER_ALARM_EN
        alarm_value = pack(0, ALARM_SS);
`endif

        tbl.push_back(mkv(mkin(1, 0, '0,          1, 0, 0, 0),  0,  0, 0, 0));
        tbl.push_back(mkv(mkin(0, 1, pack(0, 58), 1, 0, 0, 0),  0, 58, 0, 0));
        tbl.push_back(mkv(mkin(0, 0, '0,          1, 1, 0, 0),  0, 58, 1, 0));
        tbl.push_back(mkv(mkin(0, 0, '0,          1, 0, 0, 1),  0, 59, 1, 0));
        tbl.push_back(mkv(mkin(0, 0, '0,          1, 0, 0, 1),  1,  0, 1, 0));
        tbl.push_back(mkv(mkin(0, 1, pack(0, 1),  0, 0, 0, 0),  0,  1, 0, 0));
        tbl.push_back(mkv(mkin(0, 0, '0,          0, 1, 0, 0),  0,  1, 1, 0));
        tbl.push_back(mkv(mkin(0, 0, '0,          0, 0, 0, 1),  0,  0, 0, 1));
        tbl.push_back(mkv(mkin(0, 0, '0,          0, 0, 0, 1),  0,  0, 0, 0));
        tbl.push_back(mkv(mkin(0, 0, '0,          0, 1, 0, 1),  0,  0, 0, 0));
        raw = {4'd0, 4'd0, 3'd7, 4'd12};
        tbl.push_back(mkv(mkin(0, 1, raw,         1, 1, 0, 0),  0, 59, 0, 0));
        raw = {4'd15, 4'd10, 3'd6, 4'd9};
        tbl.push_back(mkv(mkin(0, 1, raw,         1, 0, 0, 0), 99, 59, 0, 0));
        tbl.push_back(mkv(mkin(0, 0, '0,          1, 1, 0, 0), 99, 59, 1, 0));
        tbl.push_back(mkv(mkin(0, 0, '0,          1, 0, 0, 1), 99, 59, 0, 1));
        tbl.push_back(mkv(mkin(0, 1, pack(10, 30), 1, 0, 0, 0), 10, 30, 0, 0));
        tbl.push_back(mkv(mkin(0, 0, '0,          1, 1, 0, 0), 10, 30, 1, 0));
        tbl.push_back(mkv(mkin(1, 1, pack(5, 0),  1, 1, 0, 1),  0,  0, 0, 0));
        tbl.push_back(mkv(mkin(0, 1, pack(0, 10), 1, 0, 0, 0),  0, 10, 0, 0));
        tbl.push_back(mkv(mkin(0, 0, '0,          1, 1, 0, 0),  0, 10, 1, 0));
        tbl.push_back(mkv(mkin(0, 0, '0,          1, 0, 0, 1),  0, 11, 1, 0));
        tbl.push_back(mkv(mkin(0, 0, '0,          1, 0, 1, 1),  0, 11, 0, 0));
        tbl.push_back(mkv(mkin(0, 0, '0,          1, 0, 0, 1),  0, 11, 0, 0));
        tbl.push_back(mkv(mkin(0, 0, '0,          1, 1, 0, 0),  0, 11, 1, 0));
        tbl.push_back(mkv(mkin(0, 0, '0,          0, 0, 0, 1),  0, 10, 1, 0));

        foreach (tbl[k]) begin
            apply(tbl[k].i);
            nm = $sformatf("vec%0d", k);
            chk({nm, " count"},   {s_min, s_sh, s_sl}, tbl[k].ecnt);
            chk({nm, " running"}, s_run,  tbl[k].erun);
            chk({nm, " done"},    s_done, tbl[k].edone);
            check_wrap_model(nm);
        end

        // Wrap build rolling over from the up limit keeps running.
        apply(mkin(0, 1, pack(99, 59), 1, 0, 0, 0));
        apply(mkin(0, 0, '0, 1, 1, 0, 0));
        apply(mkin(0, 0, '0, 1, 0, 0, 1));
        chk("wrap rollover count",   {w_min, w_sh, w_sl}, pack(0, 0));
        chk("wrap rollover done",    w_done, 1'b1);
        chk("wrap rollover running", w_run,  1'b1);
        apply(mkin(0, 0, '0, 1, 0, 0, 0));
        chk("wrap done single", w_done, 1'b0);

`ifdef TIMER_ALARM_EN
        apply(mkin(0, 1, pack(0, 0), 1, 0, 0, 0));
        apply(mkin(0, 0, '0, 1, 1, 0, 0));
        for (int t = 1; t <= 3; t++) begin
            apply(mkin(0, 0, '0, 1, 0, 0, 1));
            chk($sformatf("alarm tick%0d", t), s_alarm, (t == 3));
        end
        apply(mkin(0, 0, '0, 1, 0, 0, 0));
        chk("alarm single pulse", s_alarm, 1'b0);
        apply(mkin(0, 1, pack(0, 3), 1, 0, 0, 0));
        chk("alarm after load", s_alarm, 1'b0);
`endif

        ud = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 3))
                0: raw = 15'($urandom);
                1: raw = pack(99, $urandom_range(55, 59));
                2: raw = pack(0, $urandom_range(0, 4));
                default: raw = pack($urandom_range(0, 99), $urandom_range(0, 59));
            endcase
            if ($urandom_range(0, 9) == 0) ud = ~ud;
            apply(mkin($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0, raw, ud,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                       $urandom_range(0, 9) < 7));
            nm = $sformatf("rand%0d", c);
            check_stop_model(nm);
            check_wrap_model(nm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_mmss_bcd.md
TIMER_MMSS_BCD -- requirements
Module: timer_mmss_bcd

Interface
REQ-001 SHALL have parameter MIN_DIGITS, default 2, number of BCD minute digits (legal 1..3).
REQ-002 SHALL have parameter STOP_AT_LIMIT, default 1; 1 = halt at limit, 0 = wrap.
REQ-003 SHALL use clk (in, 1): the single clock; all state updates on rising edge.
REQ-004 SHALL use reset (in, 1): synchronous, active-high reset.
REQ-005 SHALL have enable (in, 1): one-second tick qualifier, with at most one advance per enabled cycle.
REQ-006 SHALL have up_down (in, 1): 1 = count up, 0 = count down.
REQ-007 SHALL have start (in, 1) and stop (in, 1): run-control strobes, level-sampled each cycle.
REQ-008 SHALL have load (in, 1) and load_value (in, 4*MIN_DIGITS+7), BCD packed as {minutes MS..LS, sec_high[2:0], sec_low[3:0]}.
REQ-009 SHALL have sec_low_digit (out, 4), sec_high_digit (out, 3) and min_digits (out, 4*MIN_DIGITS), all registered.
REQ-010 SHALL have running (out, 1): high in RUN.
REQ-011 SHALL have done (out, 1): one-cycle pulse on limit reach or wrap.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, HOLD, DONE.
REQ-013 SHALL apply input priority per cycle: reset > load > stop > start.
REQ-014 SHALL, on load, capture load_value into the digits next cycle, from any state, and go to IDLE.
REQ-015 SHALL clamp loaded digits: any minute or sec_low digit >9 loads as 9; sec_high >5 loads as 5.
REQ-016 SHALL go from IDLE or HOLD to RUN on start; start in RUN or DONE has no effect.
REQ-017 SHALL go from RUN to HOLD on stop; stop in any other state has no effect.
REQ-018 SHALL, in RUN with enable=1, advance count by one second in the up_down direction, visible the next cycle; enable=0 or not in RUN freezes all digits.
REQ-019 SHALL carry sec_low 9->0 up into sec_high, and sec_high 5->0 up into minute LS; minute digits 9->0 carry into the next digit.
REQ-020 SHALL mirror REQ-019 downward as borrows (0->9 and 0->5).
REQ-021 SHALL define the up limit as all minute digits 9 with sec 59, and the down limit as all zeros.
REQ-022 SHALL, when STOP_AT_LIMIT=1 and a tick lands on the limit, hold the count at the limit, pulse done, and go to DONE.
REQ-023 SHALL, when STOP_AT_LIMIT=1 and already at the limit for the current direction in RUN, go to DONE on the next tick without changing count, and pulse done.
REQ-024 SHALL, when STOP_AT_LIMIT=0 and ticking at the limit, wrap (up: max->0, down: 0->max), pulse done, and remain in RUN.
REQ-025 SHALL let an up_down change in RUN take effect on the next tick, with no lost or double step.
REQ-026 SHALL leave DONE only via load or reset.

Reset
REQ-027 SHALL, on reset, zero all digits, enter IDLE, and drive running=0 and done=0 the following cycle.
REQ-028 SHALL let reset mid-run override a same-cycle tick, load or start.

Configuration
REQ-029 SHALL, with macro TIMER_ALARM_EN defined, add alarm_value (in, 4*MIN_DIGITS+7, same packing) and alarm (out, 1).
REQ-030 SHALL, with TIMER_ALARM_EN defined, pulse alarm for one cycle when a RUN tick makes the count equal alarm_value.
REQ-031 SHALL, with TIMER_ALARM_EN defined, not assert alarm from a load that equals alarm_value.
REQ-032 SHALL, without TIMER_ALARM_EN, have neither alarm port nor alarm logic present; all other behaviour is identical.

Structure
REQ-033 SHALL take the state enum, the digit maxima (9, 5) and the field-width helper from shared package timer_pkg.
REQ-034 SHALL build digits from one sub-module bcd_digit_counter, parametrised by modulus and width, with carry/borrow in and out and a clamped load.

Verification
REQ-035 SHALL cover: load 00:58, up, start, 2 ticks -> 01:00; done=0.
REQ-036 SHALL cover: MIN_DIGITS=2, STOP_AT_LIMIT=1, load 00:01, down, start, 2 ticks -> 00:00 after tick 1 with done pulse and DONE; tick 2 -> count unchanged, no second done.
REQ-037 SHALL cover: STOP_AT_LIMIT=0, load 99:59, up, 1 tick -> 00:00, done pulse, running stays 1.
REQ-038 SHALL cover: load value sec_high=7, sec_low=12 -> reads 59; with load and start in the same cycle -> IDLE.
REQ-039 SHALL cover: in RUN at 10:30, reset with enable=1 -> next cycle 00:00, IDLE, running=0.
REQ-040 SHALL cover: with TIMER_ALARM_EN, alarm_value 00:03, load 00:00, up, 3 ticks -> alarm single pulse on tick 3; reload 00:03 -> no alarm.
